// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_mp_pkg;

    // Architectural defaults shared with the rest of the core.
    localparam int REG_ADDR_BITS        = 5;
    localparam int DATA_BUS_BITS        = 32;
    localparam int REG_FILE_CLR_PER_CYC = 4;
    localparam int REG_STATUS_IDX       = 10;

    // Lifecycle of the array: sweep-clear after reset, then normal operation.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Per-address write winner select: among enabled write ports targeting
// the queried address, the highest-index port supplies the data.
module regfile_wr_arbiter
    import regfile_mp_pkg::*;
#(
    parameter int NUM_WR = 2,
    parameter int AW     = REG_ADDR_BITS,
    parameter int DATA_W = DATA_BUS_BITS
)(
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    // Scan ports low to high so the last match (highest index) wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_addr[i*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, per-register
// pending scoreboard and a sequenced clear sweep after reset.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W      = DATA_BUS_BITS,
    parameter int NUM_REGS    = 32,
    parameter int NUM_RD      = 3,
    parameter int NUM_WR      = 2,
    parameter int CLR_PER_CYC = REG_FILE_CLR_PER_CYC,
    parameter int BYPASS      = 1,
    parameter int STATUS_REG  = REG_STATUS_IDX,
    localparam int AW         = $clog2(NUM_REGS)
)(
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     pend_set,
    input  logic [AW-1:0]            pend_addr,
    output logic [DATA_W-1:0]        status_code
);

    localparam logic [AW-1:0] LAST_GRP = AW'(NUM_REGS - CLR_PER_CYC);
    localparam logic [AW-1:0] GRP_STEP = AW'(CLR_PER_CYC);

    rf_state_t          state;
    logic [AW-1:0]      idx;
    logic [DATA_W-1:0]  regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;

    // Writes only count once the sweep has finished.
    logic [NUM_WR-1:0]  wr_live;
    assign wr_live = wr_en & {NUM_WR{ready}};

    // Per-register write winners (register 0 is hardwired and never written).
    logic [NUM_REGS-1:0] reg_hit;
    logic [DATA_W-1:0]   reg_win [NUM_REGS];

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg_arb
        if (r == 0) begin : g_zero
            assign reg_hit[r] = 1'b0;
            assign reg_win[r] = '0;
        end else begin : g_arb
            regfile_wr_arbiter #(
                .NUM_WR (NUM_WR),
                .AW     (AW),
                .DATA_W (DATA_W)
            ) u_arb (
                .wr_en   (wr_live),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .addr    (AW'(r)),
                .hit     (reg_hit[r]),
                .data    (reg_win[r])
            );
        end
    end

    // Sweep sequencer: clears CLR_PER_CYC registers per cycle, then runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    idx <= idx + GRP_STEP;
                    if (idx == LAST_GRP) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zeroed group by group during the sweep, written by winners after.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            for (int c = 0; c < CLR_PER_CYC; c++) begin
                regs[idx + AW'(c)] <= '0;
            end
        end else if (ready) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (reg_hit[r]) begin
                    regs[r] <= reg_win[r];
                end
            end
        end
    end

    // Pending scoreboard: writes clear, pend_set sets, set beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else if (ready) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (pend_set && (pend_addr == AW'(r))) begin
                    pend[r] <= 1'b1;
                end else if (reg_hit[r]) begin
                    pend[r] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              byp_hit;
        logic [DATA_W-1:0] byp_data;
        logic              live;

        assign ra   = rd_addr[k*AW +: AW];
        assign live = ready && (ra != '0);

        regfile_wr_arbiter #(
            .NUM_WR (NUM_WR),
            .AW     (AW),
            .DATA_W (DATA_W)
        ) u_byp (
            .wr_en   (wr_live),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .addr    (ra),
            .hit     (byp_hit),
            .data    (byp_data)
        );

        assign rd_pend[k] = live && pend[ra];
        assign rd_data[k*DATA_W +: DATA_W] =
            !live                        ? '0       :
            (BYPASS != 0 && byp_hit)     ? byp_data :
                                           regs[ra];
    end

    assign status_code = ready ? regs[STATUS_REG] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp with default parameters.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           ready;
    logic [3*AW-1:0] rd_addr;
    logic [3*DW-1:0] rd_data;
    logic [2:0]     rd_pend;
    logic [1:0]     wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic           pend_set;
    logic [AW-1:0]  pend_addr;
    logic [DW-1:0]  status_code;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_pend     (rd_pend),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pend_set    (pend_set),
        .pend_addr   (pend_addr),
        .status_code (status_code)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rdd(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic idle();
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        pend_set  = 1'b0;
        pend_addr = '0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        idle();
        rd_addr = '0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_rd(0, 5'd5);
        set_wr(0, 5'd5, 32'h0000_0055);
        pend_set  = 1'b1;
        pend_addr = 5'd5;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b want 0", ready);
        end
        n_checks++;
        if (rdd(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h want 0", rdd(0));
        end
        cnt = 0;
        while (ready !== 1'b1 && cnt < 20) begin
            cnt++;
            next_cycle();
        end
        idle();
        #1;
        n_checks++;
        if (cnt !== 8) begin
            n_fail++;
            $display("FAIL sweep_cycles: got %0d want 8", cnt);
        end
        n_checks++;
        if (rdd(0) !== 32'h0 || rd_pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_x5_ignored: got data %h pend %0b want 0/0", rdd(0), rd_pend[0]);
        end
        for (int r = 0; r < 32; r++) begin
            set_rd(1, AW'(r));
            #1;
            n_checks++;
            if (rdd(1) !== 32'h0 || rd_pend[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_zero x%0d: got data %h pend %0b want 0/0", r, rdd(1), rd_pend[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        idle();
        set_wr(0, 5'd6, 32'h6666);
        next_cycle();
        idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        repeat (4) next_cycle();
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_sweep_ready: got %0b want 0", ready);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 20) begin
            cnt++;
            next_cycle();
        end
        n_checks++;
        if (cnt !== 8) begin
            n_fail++;
            $display("FAIL mid_sweep_restart: got %0d cycles want 8", cnt);
        end
        set_rd(0, 5'd6);
        #1;
        n_checks++;
        if (rdd(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_sweep_x6_cleared: got %h want 0", rdd(0));
        end
    endtask

    task automatic test_priority();
        idle();
        set_rd(0, 5'd7);
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        #1;
        n_checks++;
        if (rdd(0) !== 32'h22) begin
            n_fail++;
            $display("FAIL prio_bypass: got %h want 00000022", rdd(0));
        end
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (rdd(0) !== 32'h22) begin
            n_fail++;
            $display("FAIL prio_stored: got %h want 00000022", rdd(0));
        end
        set_wr(0, 5'd8, 32'h88);
        set_wr(1, 5'd9, 32'h99);
        set_rd(0, 5'd8);
        set_rd(1, 5'd9);
        set_rd(2, 5'd7);
        #1;
        n_checks++;
        if (rdd(0) !== 32'h88 || rdd(1) !== 32'h99 || rdd(2) !== 32'h22) begin
            n_fail++;
            $display("FAIL dual_write_bypass: got %h %h %h want 88 99 22", rdd(0), rdd(1), rdd(2));
        end
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (rdd(0) !== 32'h88 || rdd(1) !== 32'h99) begin
            n_fail++;
            $display("FAIL dual_write_stored: got %h %h want 88 99", rdd(0), rdd(1));
        end
    endtask

    task automatic test_reg0();
        idle();
        set_rd(0, 5'd0);
        set_wr(0, 5'd0, 32'hFFFF);
        set_wr(1, 5'd0, 32'h1234);
        pend_set  = 1'b1;
        pend_addr = 5'd0;
        #1;
        n_checks++;
        if (rdd(0) !== 32'h0 || rd_pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_no_bypass: got data %h pend %0b want 0/0", rdd(0), rd_pend[0]);
        end
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (rdd(0) !== 32'h0 || rd_pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_stored: got data %h pend %0b want 0/0", rdd(0), rd_pend[0]);
        end
    endtask

    task automatic test_pend();
        idle();
        set_rd(1, 5'd3);
        pend_set  = 1'b1;
        pend_addr = 5'd3;
        #1;
        n_checks++;
        if (rd_pend[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_set_same_cycle: got %0b want 0", rd_pend[1]);
        end
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (rd_pend[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set_next: got %0b want 1", rd_pend[1]);
        end
        set_wr(0, 5'd3, 32'h33);
        #1;
        n_checks++;
        if (rd_pend[1] !== 1'b1 || rdd(1) !== 32'h33) begin
            n_fail++;
            $display("FAIL pend_clear_same_cycle: got pend %0b data %h want 1/33", rd_pend[1], rdd(1));
        end
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (rd_pend[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_clear_next: got %0b want 0", rd_pend[1]);
        end
        set_wr(0, 5'd3, 32'h3333);
        pend_set  = 1'b1;
        pend_addr = 5'd3;
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (rd_pend[1] !== 1'b1 || rdd(1) !== 32'h3333) begin
            n_fail++;
            $display("FAIL pend_set_wins: got pend %0b data %h want 1/3333", rd_pend[1], rdd(1));
        end
        set_wr(1, 5'd3, 32'h4444);
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (rd_pend[1] !== 1'b0 || rdd(1) !== 32'h4444) begin
            n_fail++;
            $display("FAIL pend_clear_port1: got pend %0b data %h want 0/4444", rd_pend[1], rdd(1));
        end
    endtask

    task automatic test_status();
        idle();
        set_rd(2, 5'd10);
        set_wr(1, 5'd10, 32'hDEAD);
        #1;
        n_checks++;
        if (status_code !== 32'h0) begin
            n_fail++;
            $display("FAIL status_no_bypass: got %h want 0", status_code);
        end
        n_checks++;
        if (rdd(2) !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL status_port_bypass: got %h want 0000dead", rdd(2));
        end
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (status_code !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL status_next: got %h want 0000dead", status_code);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        set_rd(0, 5'd12);
        set_wr(0, 5'd12, 32'hA1);
        #1;
        n_checks++;
        if (rdd(0) !== 32'hA1) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want a1", rdd(0));
        end
        next_cycle();
        idle();
        set_wr(1, 5'd12, 32'hA2);
        #1;
        n_checks++;
        if (rdd(0) !== 32'hA2) begin
            n_fail++;
            $display("FAIL b2b_second: got %h want a2", rdd(0));
        end
        next_cycle();
        idle();
        #1;
        n_checks++;
        if (rdd(0) !== 32'hA2) begin
            n_fail++;
            $display("FAIL b2b_stored: got %h want a2", rdd(0));
        end
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        idle();
        test_reset();
        test_reset_mid();
        test_priority();
        test_reg0();
        test_pend();
        test_status();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core; successor to the single-write, dual-read register file.
- Provides NUM_RD read ports and NUM_WR write ports, with optional same-cycle write-to-read bypass.
- Includes a per-register pending scoreboard for hazard detection.
- Clears the array with a sequenced sweep after reset instead of a single-cycle clear.

Parameters:
- DATA_W, `DataBusBits, register data width.
- NUM_REGS, 32, number of architectural registers (power of two, >=2).
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write ports.
- CLR_PER_CYC, 4, registers zeroed per clock during the clear sweep (must divide NUM_REGS).
- BYPASS, 1, 1 = forward same-cycle write data to reads; 0 = reads return stored value only.
- STATUS_REG, 10, register index mirrored on status_code.
- Localparam AW = $clog2(NUM_REGS); AW equals `RegAddrBits when NUM_REGS = 32.

Ports:
- clk  in  1  clock; every state update occurs on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sweep is complete.
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*DW  read data (combinational); DW = DATA_W.
- rd_pend  out  NUM_RD  pending flag of each read address (combinational).
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*DW  write data.
- pend_set  in  1  mark pend_addr as having an in-flight producer.
- pend_addr  in  AW  register to mark pending.
- status_code  out  DW  stored value of register STATUS_REG (no bypass).

Behaviour:
- FSM states: CLEAR and RUN.
- While reset=1: state goes to CLEAR, the sweep index goes to 0, all pending bits go to 0, and ready=0.
- CLEAR: each cycle, zero registers idx..idx+CLR_PER_CYC-1, then idx += CLR_PER_CYC.
  - After the last group, go to RUN.
  - ready rises NUM_REGS/CLR_PER_CYC cycles after reset deasserts (8 with defaults).
- Reset asserted mid-sweep restarts the sweep at idx 0.
- While ready=0:
  - Writes and pend_set are ignored.
  - rd_data = 0, rd_pend = 0, status_code = 0.
- Register 0:
  - Writes to address 0 are discarded; reads of address 0 always return 0.
  - pend_set on address 0 is ignored, so rd_pend is never 1 for address 0.
- Write ports:
  - A write takes effect at the rising edge of the cycle in which wr_en is high and ready=1.
  - When several ports target the same address, the highest-index port wins.
- Read value:
  - BYPASS=1: if any enabled write port in the current cycle targets the read address (not 0, ready=1), rd_data returns the winning port's wr_data. Otherwise it returns the stored value.
  - BYPASS=0: rd_data returns the stored value; new data is visible the cycle after the write.
- Pending scoreboard: one bit per register, updated at the clock edge.
  - Each enabled write clears the bit of its address.
  - pend_set sets the bit of pend_addr.
  - If pend_set and a write hit the same address in the same cycle, set wins (the new producer supersedes).
  - rd_pend reflects registered bits only; there is no bypass of the same-cycle set or clear.
- Reads are purely combinational: zero latency for both rd_data and rd_pend.
- status_code is the stored value only, one cycle after the write.

Decomposition:
- Extend diagv2_const.vh with `RegFileClrPerCyc and `RegStatusIdx.
- Reuse the existing `RegAddrBits, `DataBusBits, `DataZero and `RegZero constants.
- One natural sub-module, regfile_wr_arbiter: a combinational per-address winner select across write ports.
  - Used for both the array update and the bypass mux.

Test Plan:
- Sweep timing: hold reset for 3 cycles, then release. ready must be 0 for exactly 8 cycles and 1 on the 9th. Every register must read 0. Writes to x5 during the sweep must have no effect.
- Reset mid-sweep: reassert reset at sweep cycle 4. ready must stay low, and the sweep must restart so that ready rises 8 cycles after the second release.
- Same-address write priority: wr0 writes x7=0x11 and wr1 writes x7=0x22 in the same cycle, with rd_addr0=x7.
  - BYPASS=1: rd_data0 = 0x22 in that cycle.
  - Next cycle: x7 = 0x22 (for both BYPASS settings).
- Register 0: write x0=0xFFFF and pend_set x0. rd_data and rd_pend for x0 must stay 0. With BYPASS=1, no bypass occurs on x0.
- Pending flags:
  - pend_set x3 → rd_pend=1 on the next cycle.
  - Write x3 → flag cleared on the next cycle.
  - Simultaneous pend_set x3 and write x3 → flag remains 1, and the data is still written.
- Status output: write x10=0xDEAD. status_code = 0xDEAD one cycle later. It must be unaffected by the bypass path in the cycle of the write.
